// File: rtl/irq1_mutex_arbiter.sv
// IRQ1 sequencer: synchronises ext_signal, queues its rising edges and shares the
// interrupt between node0 and node1 as a one-hot grant held until ack or timeout.
module irq1_mutex_arbiter #(
  parameter int PULSE_LEN   = 1000,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ext_signal,
  input  logic [15:0]      in_op_node0,
  input  logic [15:0]      in_op_node1,
  input  logic             ack_node0,
  input  logic             ack_node1,
  output logic [1:0]       out_mutex_IRQ1,
  output logic             busy,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             overflow,
  output logic             timeout_pulse,
  output logic [3:0]       prio_node0,
  output logic [3:0]       prio_node1,
  output logic [1:0]       o_dbg_state
);

  localparam int GCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [GCNT_W-1:0] GCNT_TERM = GCNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARB     = 2'd1,
    S_GRANT   = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GCNT_W-1:0]   r_gcnt;
  logic [GCNT_W-1:0]   w_gcnt_nxt;
  logic                r_winner;
  logic                w_winner_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic [1:0]          r_mutex;
  logic [1:0]          w_mutex_nxt;
  logic                r_timeout;
  logic                w_timeout_nxt;
  logic                r_busy;
  logic [CNT_W-1:0]    r_pending;
  logic [CNT_W-1:0]    w_pending_nxt;
  logic                r_overflow;
  logic                w_overflow_nxt;
  logic [3:0]          r_prio0;
  logic [3:0]          r_prio1;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                r_hist;

  logic w_event;
  logic w_take;
  logic w_any_prio;
  logic w_pick1;
  logic w_win_ack;
  logic w_op0_hit;
  logic w_op1_hit;

  // ext_signal is asynchronous; only the synchronised copy is edge-detected.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ext_signal};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_event = r_sync[SYNC_STAGES-1] & ~r_hist;

  assign w_op0_hit = (in_op_node0 & 16'h3FF0) == 16'h2F10;
  assign w_op1_hit = (in_op_node1 & 16'h3FF0) == 16'h2F10;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_prio0 <= 4'd2;
      r_prio1 <= 4'd4;
    end else begin
      if (w_op0_hit) r_prio0 <= in_op_node0[3:0];
      if (w_op1_hit) r_prio1 <= in_op_node1[3:0];
    end
  end

  // Tie goes to the node that did not win last time; r_last = 1 means node1.
  assign w_any_prio = (r_prio0 != 4'd0) || (r_prio1 != 4'd0);
  assign w_pick1    = (r_prio1 > r_prio0) || ((r_prio1 == r_prio0) && !r_last);
  assign w_win_ack  = r_winner ? ack_node1 : ack_node0;

  always_comb begin
    w_state_nxt   = r_state;
    w_gcnt_nxt    = r_gcnt;
    w_winner_nxt  = r_winner;
    w_last_nxt    = r_last;
    w_mutex_nxt   = r_mutex;
    w_timeout_nxt = 1'b0;
    w_take        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_pending != '0) && w_any_prio) w_state_nxt = S_ARB;
      end
      S_ARB: begin
        if (!w_any_prio) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_take       = 1'b1;
          w_winner_nxt = w_pick1;
          w_last_nxt   = w_pick1;
          w_gcnt_nxt   = '0;
          w_mutex_nxt  = w_pick1 ? 2'b10 : 2'b01;
          w_state_nxt  = S_GRANT;
        end
      end
      S_GRANT: begin
        // An ack on the terminal count wins over the timeout.
        if (w_win_ack) begin
          w_mutex_nxt = 2'b00;
          w_state_nxt = S_RELEASE;
        end else if (r_gcnt == GCNT_TERM) begin
          w_mutex_nxt   = 2'b00;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_RELEASE;
        end else begin
          w_gcnt_nxt = r_gcnt + GCNT_W'(1);
        end
      end
      S_RELEASE: begin
        w_gcnt_nxt  = '0;
        w_mutex_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gcnt_nxt  = '0;
        w_mutex_nxt = 2'b00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_pending_nxt  = r_pending;
    w_overflow_nxt = r_overflow;
    if (w_event && !w_take) begin
      if (r_pending == CNT_MAX) w_overflow_nxt = 1'b1;
      else                      w_pending_nxt  = r_pending + CNT_W'(1);
    end else if (!w_event && w_take) begin
      w_pending_nxt = r_pending - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_gcnt     <= '0;
      r_winner   <= 1'b0;
      r_last     <= 1'b1;
      r_mutex    <= 2'b00;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gcnt     <= w_gcnt_nxt;
      r_winner   <= w_winner_nxt;
      r_last     <= w_last_nxt;
      r_mutex    <= w_mutex_nxt;
      r_timeout  <= w_timeout_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_pending  <= w_pending_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  assign out_mutex_IRQ1 = r_mutex;
  assign busy           = r_busy;
  assign pending_cnt    = r_pending;
  assign overflow       = r_overflow;
  assign timeout_pulse  = r_timeout;
  assign prio_node0     = r_prio0;
  assign prio_node1     = r_prio1;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_irq1_mutex_arbiter.sv
// Bench for irq1_mutex_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle and grant by grant against a behavioural model.
module tb_irq1_mutex_arbiter;

  localparam int PULSE_LEN   = 1000;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;
  localparam int PMAX        = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             ext_signal = 1'b0;
  logic [15:0]      in_op_node0 = '0;
  logic [15:0]      in_op_node1 = '0;
  logic             ack_node0 = 1'b0;
  logic             ack_node1 = 1'b0;
  logic [1:0]       out_mutex_IRQ1;
  logic             busy;
  logic [CNT_W-1:0] pending_cnt;
  logic             overflow;
  logic             timeout_pulse;
  logic [3:0]       prio_node0;
  logic [3:0]       prio_node1;
  logic [1:0]       dbg_state;

  irq1_mutex_arbiter #(
    .PULSE_LEN(PULSE_LEN), .SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .ext_signal(ext_signal),
    .in_op_node0(in_op_node0), .in_op_node1(in_op_node1),
    .ack_node0(ack_node0), .ack_node1(ack_node1),
    .out_mutex_IRQ1(out_mutex_IRQ1), .busy(busy), .pending_cnt(pending_cnt),
    .overflow(overflow), .timeout_pulse(timeout_pulse),
    .prio_node0(prio_node0), .prio_node1(prio_node1), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_miss = 0;
  logic [13:0] exp_q[$];  // {grant one-hot, grant length, ended by timeout}

  task automatic report();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      if (n_miss >= 200) begin
        report();
        $finish;
      end
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 waiting, 1 choosing, 2 granted, 3 cooling off.
  int m_stage = 0;
  int m_pend  = 0;
  bit m_ovf   = 1'b0;
  int m_p0    = 2;
  int m_p1    = 4;
  int m_last  = 1;
  int m_owner = 0;
  int m_age   = 0;
  bit m_to    = 1'b0;
  bit x_q[$];  // last SYNC_STAGES+1 samples of ext_signal, oldest first

  task automatic model_reset();
    m_stage = 0; m_pend = 0; m_ovf = 1'b0; m_p0 = 2; m_p1 = 4;
    m_last = 1; m_owner = 0; m_age = 0; m_to = 1'b0;
    x_q.delete();
    for (int i = 0; i <= SYNC_STAGES; i++) x_q.push_back(1'b0);
  endtask

  task automatic model_step();
    bit ev;
    bit take;
    bit owner_ack;
    int ns;
    int win;
    ev = x_q[1] && !x_q[0];
    void'(x_q.pop_front());
    x_q.push_back(ext_signal);
    take = 1'b0;
    ns = m_stage;
    m_to = 1'b0;
    owner_ack = (m_owner == 1) ? ack_node1 : ack_node0;
    if (m_stage == 0) begin
      if (m_pend > 0 && (m_p0 != 0 || m_p1 != 0)) ns = 1;
    end else if (m_stage == 1) begin
      if (m_p0 == 0 && m_p1 == 0) ns = 0;
      else begin
        if (m_p0 > m_p1)      win = 0;
        else if (m_p1 > m_p0) win = 1;
        else                  win = 1 - m_last;
        m_owner = win; m_last = win; m_age = 0; take = 1'b1; ns = 2;
      end
    end else if (m_stage == 2) begin
      if (owner_ack) begin
        exp_q.push_back({(m_owner == 1) ? 2'b10 : 2'b01, 11'(m_age + 1), 1'b0});
        ns = 3;
      end else if (m_age == PULSE_LEN - 1) begin
        exp_q.push_back({(m_owner == 1) ? 2'b10 : 2'b01, 11'(m_age + 1), 1'b1});
        m_to = 1'b1;
        ns = 3;
      end else m_age++;
    end else ns = 0;
    if (ev && !take) begin
      if (m_pend == PMAX) m_ovf = 1'b1;
      else m_pend++;
    end else if (take && !ev) m_pend--;
    if ((in_op_node0 & 16'h3FF0) == 16'h2F10) m_p0 = int'(in_op_node0[3:0]);
    if ((in_op_node1 & 16'h3FF0) == 16'h2F10) m_p1 = int'(in_op_node1[3:0]);
    m_stage = ns;
  endtask

  initial model_reset();

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) model_reset();
    else model_step();
  end

  // ---------------- monitor ----------------
  logic [1:0] d_who = 2'b00;
  int d_len = 0;
  logic [16:0] obs_v;
  logic [16:0] exp_v;
  logic [13:0] word;

  always @(posedge CLK) begin
    #2;
    obs_v = {out_mutex_IRQ1, busy, pending_cnt, overflow, timeout_pulse, prio_node0, prio_node1};
    exp_v = {(m_stage == 2) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00,
             (m_stage != 0), CNT_W'(m_pend), m_ovf, m_to, 4'(m_p0), 4'(m_p1)};
    check("outputs", 32'(obs_v), 32'(exp_v));
    if (!RST_N) begin
      d_who = 2'b00;
      d_len = 0;
    end else if (out_mutex_IRQ1 != 2'b00) begin
      if (d_who == 2'b00) begin
        d_who = out_mutex_IRQ1;
        d_len = 1;
      end else d_len++;
    end else if (d_who != 2'b00) begin
      word = {d_who, 11'(d_len), timeout_pulse};
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL grant_unexpected: got %0h, want none (t=%0t)", word, $time);
      end else check("grant", 32'(word), 32'(exp_q.pop_front()));
      d_who = 2'b00;
    end
  end

  // ---------------- ack driver ----------------
  int cfg_ack   = -1;   // -1 never ack (timeout), >=0 fixed grant cycle, -2 random
  bit cfg_noise = 1'b0; // random acks from the node that does not hold the grant
  int cur_delay = -1;

  always @(negedge CLK) begin
    if (m_stage == 2 && m_age == 0)
      cur_delay = (cfg_ack >= -1) ? cfg_ack : int'($urandom_range(0, 25));
    ack_node0 = (m_stage == 2 && m_owner == 0) ? (m_age == cur_delay)
                                               : (cfg_noise && $urandom_range(0, 7) == 0);
    ack_node1 = (m_stage == 2 && m_owner == 1) ? (m_age == cur_delay)
                                               : (cfg_noise && $urandom_range(0, 7) == 0);
  end

  // ---------------- stimulus tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse();
    ext_signal = 1'b1;
    tick($urandom_range(1, 3));
    ext_signal = 1'b0;
    tick($urandom_range(1, 3));
  endtask

  task automatic send_ops(input logic [15:0] op0, input logic [15:0] op1);
    in_op_node0 = op0;
    in_op_node1 = op1;
    tick(1);
    in_op_node0 = '0;
    in_op_node1 = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    tick(SYNC_STAGES + 2);
    while (!(m_stage == 0 && m_pend == 0) && n < budget) begin
      tick(1);
      n++;
    end
    n_vec++;
    if (n >= budget) begin
      n_miss++;
      $display("FAIL drain_timeout: waited %0d cycles, limit %0d", n, budget);
    end
  endtask

  task automatic wait_grant_cycle(input int cyc, input int budget);
    int n;
    n = 0;
    while (!(m_stage == 2 && m_age == cyc) && n < budget) begin
      tick(1);
      n++;
    end
    n_vec++;
    if (n >= budget) begin
      n_miss++;
      $display("FAIL grant_cycle_timeout: waited %0d cycles, limit %0d", n, budget);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mutex"},   32'(out_mutex_IRQ1), 32'h0);
    check({tag, "_busy"},    32'(busy),           32'h0);
    check({tag, "_pending"}, 32'(pending_cnt),    32'h0);
    check({tag, "_ovf"},     32'(overflow),       32'h0);
    check({tag, "_tmo"},     32'(timeout_pulse),  32'h0);
    check({tag, "_prio0"},   32'(prio_node0),     32'd2);
    check({tag, "_prio1"},   32'(prio_node1),     32'd4);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] op;
  int r;

  initial begin
    tick(2);
    check_reset_values("reset");
    RST_N = 1'b1;
    tick(2);

    // Default priorities, no ack: node1 held for the full timeout.
    cfg_ack = -1;
    pulse();
    wait_drain(1500);

    // node0 raised to 7, acks in grant cycle 10.
    send_ops(16'h2F17, 16'h0000);
    check("prio0_prog", 32'(prio_node0), 32'd7);
    cfg_ack = 10;
    pulse();
    wait_drain(200);

    // Equal priorities, events queued during a grant: alternating winners.
    send_ops(16'h2F15, 16'h2F15);
    cfg_ack = 30;
    pulse();
    repeat (3) pulse();
    wait_drain(400);

    // Saturation while the first grant runs to timeout.
    cfg_ack = -1;
    pulse();
    tick(6);
    cfg_ack = 3;
    repeat (17) pulse();
    tick(4);
    check("sat_pending", 32'(pending_cnt), 32'(PMAX));
    check("sat_ovf",     32'(overflow),    32'h1);
    wait_drain(2500);
    check("drain_pending", 32'(pending_cnt), 32'h0);
    check("drain_ovf",     32'(overflow),    32'h1);

    // Both nodes masked: the event waits until node0 is unmasked.
    send_ops(16'h0000, 16'h2F10);
    send_ops(16'h2F10, 16'h0000);
    pulse();
    tick(20);
    check("mask_pending", 32'(pending_cnt),    32'h1);
    check("mask_mutex",   32'(out_mutex_IRQ1), 32'h0);
    cfg_ack = 5;
    send_ops(16'hEF13, 16'h0000);
    wait_drain(200);

    // Reset in the middle of a grant, then a fresh event goes to node1.
    cfg_ack = -1;
    pulse();
    wait_grant_cycle(500, 800);
    RST_N = 1'b0;
    #1;
    check_reset_values("midrst");
    tick(2);
    RST_N = 1'b1;
    cfg_ack = 8;
    pulse();
    wait_drain(200);

    // Random traffic: opcodes (hits, near misses, idle), pulses, acks and noise.
    cfg_ack = -2;
    cfg_noise = 1'b1;
    for (int it = 0; it < 40; it++) begin
      for (int nd = 0; nd < 2; nd++) begin
        r = $urandom_range(0, 2);
        if (r == 0)      op = {2'($urandom_range(0, 3)), 10'h2F1, 4'($urandom_range(0, 15))};
        else if (r == 1) op = {2'($urandom_range(0, 3)), 10'h2F1 ^ (10'd1 << $urandom_range(0, 9)),
                               4'($urandom_range(0, 15))};
        else             op = 16'h0000;
        if (nd == 0) in_op_node0 = op;
        else         in_op_node1 = op;
      end
      tick($urandom_range(1, 3));
      in_op_node0 = '0;
      in_op_node1 = '0;
      repeat ($urandom_range(0, 3)) pulse();
      tick($urandom_range(0, 15));
    end
    send_ops(16'h2F11, 16'h2F12);
    wait_drain(4000);
    cfg_noise = 1'b0;
    tick(4);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL grants_missing: %0d expected grants never seen", exp_q.size());
    end
    report();
    $finish;
  end

  initial begin
    #2_000_000;
    n_vec++;
    n_miss++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    report();
    $finish;
  end

endmodule
